// File: rtl/rings_pkg.sv
// Shared timing defaults and width helpers for the concentric-rings pattern generator.
// Used at elaboration only. No runtime logic and no flow control.
package rings_pkg;

  localparam int H_ACTIVE_DEF   = 640;
  localparam int H_FP_DEF       = 16;
  localparam int H_SYNC_DEF     = 96;
  localparam int H_BP_DEF       = 48;
  localparam int V_ACTIVE_DEF   = 480;
  localparam int V_FP_DEF       = 10;
  localparam int V_SYNC_DEF     = 2;
  localparam int V_BP_DEF       = 33;
  localparam int CX_DEF         = 320;
  localparam int CY_DEF         = 240;
  localparam int RING_SHIFT_DEF = 10;
  localparam int COLOR_W_DEF    = 2;

  function automatic int line_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Largest squared offset from the centre along one axis of a 0..total-1 span.
  function automatic longint max_sq(input int c, input int total);
    longint a;
    longint b;
    a = longint'(c) * longint'(c);
    b = longint'(total - 1 - c) * longint'(total - 1 - c);
    return (a > b) ? a : b;
  endfunction

  function automatic int dist_w(input int ht, input int vt, input int cx, input int cy);
    longint m;
    m = max_sq(cx, ht) + max_sq(cy, vt);
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rings_vga_timing.sv
// Raster h/v counters with sync, display-enable and frame-start outputs.
// Outputs are registered one clock after the counter value they describe; the ena input stalls everything.
module vga_timing
  import rings_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int HW       = 10,
  parameter int VW       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  output logic [HW-1:0] h_o,
  output logic [VW-1:0] v_o,
  output logic          active_o,
  output logic          origin_o,
  output logic          h_wrap_o,
  output logic          f_wrap_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          de_o,
  output logic          frame_start_o
);

  localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          hsync_q, vsync_q, de_q, fs_q;
  logic          h_wrap, v_last, hs_n, vs_n;

  assign h_wrap   = (int'(h_q) == H_TOTAL - 1);
  assign v_last   = (int'(v_q) == V_TOTAL - 1);
  assign active_o = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
  assign origin_o = (h_q == '0) && (v_q == '0);
  assign h_wrap_o = h_wrap;
  assign f_wrap_o = h_wrap && v_last;

  assign hs_n = !((int'(h_q) >= H_ACTIVE + H_FP) && (int'(h_q) < H_ACTIVE + H_FP + H_SYNC));
  assign vs_n = !((int'(v_q) >= V_ACTIVE + V_FP) && (int'(v_q) < V_ACTIVE + V_FP + V_SYNC));

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_wrap) begin
      h_d = '0;
      v_d = v_last ? '0 : v_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else if (ena) begin
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hs_n;
      vsync_q <= vs_n;
      de_q    <= active_o;
      fs_q    <= origin_o;
    end
  end

  assign h_o           = h_q;
  assign v_o           = v_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign de_o          = de_q;
  assign frame_start_o = fs_q;

endmodule

// File: rtl/rings_gen.sv
// Animated concentric-rings VGA pattern: colour index from squared distance to a centre, minus a per-frame phase.
// All outputs registered one clock after their raster position; ena low freezes the whole block.
module rings_gen
  import rings_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int CX         = CX_DEF,
  parameter int CY         = CY_DEF,
  parameter int RING_SHIFT = RING_SHIFT_DEF,
  parameter int COLOR_W    = COLOR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [3:0]         speed,
  input  logic               freeze,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b,
  output logic               frame_start
);

  localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = cnt_w(H_TOTAL);
  localparam int VW      = cnt_w(V_TOTAL);
  localparam int DIST_W  = dist_w(H_TOTAL, V_TOTAL, CX, CY);
  localparam int IDX_W   = 3 * COLOR_W;

  localparam logic [DIST_W-1:0] CX2 = DIST_W'(CX * CX);
  localparam logic [DIST_W-1:0] CY2 = DIST_W'(CY * CY);

  logic [HW-1:0]      h;
  logic [VW-1:0]      v;
  logic               active, origin, h_wrap, f_wrap;
  logic [DIST_W-1:0]  dx2_q, dy2_q, dist2, ring, dx_inc, dy_inc;
  logic [IDX_W-1:0]   phase_q, idx;
  logic [3:0]         spd_q;
  logic               frz_q;
  logic [COLOR_W-1:0] r_q, g_q, b_q, r_d, g_d, b_d;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HW(HW), .VW(VW)
  ) u_timing (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .h_o           (h),
    .v_o           (v),
    .active_o      (active),
    .origin_o      (origin),
    .h_wrap_o      (h_wrap),
    .f_wrap_o      (f_wrap),
    .hsync_o       (hsync),
    .vsync_o       (vsync),
    .de_o          (de),
    .frame_start_o (frame_start)
  );

  // (d+1)^2 - d^2 = 2d+1; the two's-complement add wraps back into range since the true sum always fits.
  assign dx_inc = DIST_W'(2 * (int'(h) - CX) + 1);
  assign dy_inc = DIST_W'(2 * (int'(v) - CY) + 1);
  assign dist2  = dx2_q + dy2_q;
  assign ring   = dist2 >> RING_SHIFT;
  assign idx    = IDX_W'(ring) - phase_q;

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (active) begin
      r_d = idx[IDX_W-1 -: COLOR_W];
      g_d = idx[IDX_W-1-COLOR_W -: COLOR_W];
      b_d = idx[COLOR_W-1:0];
    end
  end

  // speed/freeze are sampled at the first pixel of a frame and applied at that frame's wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dx2_q   <= CX2;
      dy2_q   <= CY2;
      phase_q <= '0;
      spd_q   <= '0;
      frz_q   <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else if (ena) begin
      dx2_q <= h_wrap ? CX2 : dx2_q + dx_inc;
      if (f_wrap)
        dy2_q <= CY2;
      else if (h_wrap)
        dy2_q <= dy2_q + dy_inc;
      if (origin) begin
        spd_q <= speed;
        frz_q <= freeze;
      end
      if (f_wrap && !frz_q)
        phase_q <= phase_q + IDX_W'(spd_q);
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
    end
  end

  assign r = r_q;
  assign g = g_q;
  assign b = b_q;

endmodule
